game_flow_ctrl: RTL
===================

// Module: game_flow_ctrl
// PURPOSE
//   Parametrised game-flow controller for the STG top level: splash -> start -> play -> success/gameover.
//   Owns the life and bomb counters, the invulnerability and bomb windows, the game_en gate and the game_reset pulse.
//   Adds pickups (extra life/bomb) with saturation, rising-edge bomb input and collision-ignore while protected.
//   Optional pause.
// PARAMETERS
//   LIFE_W      4           life counter width
//   BOMB_W      4           bomb counter width
//   LIFE_INIT   3           lives loaded at reset and on restart
//   BOMB_INIT   3           bombs loaded at reset and on restart
//   LIFE_MAX    9           life saturation ceiling (<= 2**LIFE_W-1)
//   BOMB_MAX    9           bomb saturation ceiling (<= 2**BOMB_W-1)
//   TMR_W       32          timer width
//   SPLASH_CYC  20_000_000  cycles spent in INIT
//   INVULN_CYC  20_000_000  cycles spent in INVULN after a hit
//   BOMB_CYC    40_000_000  cycles spent in BOMB
// PORTS
//   clk           in   1       system clock
//   hard_reset_n  in   1       asynchronous, active-low reset
//   enter         in   1       start/restart key, level; rising edge acts
//   bomb          in   1       bomb key, level; rising edge acts
//   collision     in   1       player hit, level, sampled each cycle
//   die           in   1       boss defeated, level
//   life_pickup   in   1       +1 life, one-cycle pulse
//   bomb_pickup   in   1       +1 bomb, one-cycle pulse
//   pause         in   1       pause key; rising edge acts; ignored unless GAME_PAUSE_EN
//   num_life      out  LIFE_W  remaining lives
//   num_bomb      out  BOMB_W  remaining bombs
//   game_state    out  4       current state code
//   game_en       out  1       game logic enable
//   game_reset    out  1       one-cycle restart pulse to game logic
//   invuln        out  1       high in INVULN and BOMB
// BEHAVIOUR
//   Codes: INIT=0000, START=0001, PLAY=0010, PAUSE=0100, BOMB=0110, SUCCESS=1000, GAMEOVER=1001, INVULN=1010.
//   Reset (async, hard_reset_n=0):
//     state=INIT, timer=SPLASH_CYC-1, num_life=LIFE_INIT, num_bomb=BOMB_INIT
//     game_en=0, game_reset=0, edge-detect regs=0.
//     Reset mid-game aborts immediately; no pulse is emitted.
//   All outputs are registered. A rising edge counts when the input is 1 at edge N and was 0 at edge N-1; it acts at edge N.
//   Timed states: timer is loaded with CYC-1 on entry and decrements each cycle.
//     When timer==0 the state exits, so each timed state lasts exactly CYC cycles.
//   INIT: at timer==0 -> START.
//   START: enter edge -> PLAY, game_en=1, game_reset=1 for exactly one cycle.
//   PLAY, one action per cycle, priority die > collision > bomb:
//     die -> SUCCESS.
//     collision with num_life==1 -> num_life=0, game_en=0, GAMEOVER.
//     collision with num_life>1 -> num_life-1, INVULN.
//     bomb edge with num_bomb>0 -> num_bomb-1, BOMB. Bomb edge with num_bomb==0 is ignored.
//   INVULN: collision ignored. die -> SUCCESS. bomb edge with num_bomb>0 -> BOMB (timer reloaded). timer==0 -> PLAY.
//   BOMB: collision and bomb ignored. die -> SUCCESS. timer==0 -> PLAY.
//   Pickups are accepted in PLAY, INVULN and BOMB only:
//     +1, saturating at LIFE_MAX/BOMB_MAX.
//     A pickup in the same cycle as a decrement cancels it (net 0).
//   SUCCESS/GAMEOVER: game_en=0.
//     enter edge -> counters reload INIT values, game_reset 1-cycle pulse, INIT with timer=SPLASH_CYC-1.
//   No counter ever wraps: decrements occur only from nonzero values, increments saturate.
// CONFIGURATION
//   GAME_PAUSE_EN defined:
//     pause edge in PLAY/INVULN/BOMB -> PAUSE; the return state is saved and the timer is frozen.
//     game_en=0 in PAUSE; all other inputs ignored.
//     Next pause edge -> return to the saved state with the timer intact and game_en=1.
//   GAME_PAUSE_EN undefined: the pause port is unused, PAUSE is unreachable, no save register exists.
// STRUCTURE
//   game_pkg: state code localparams and default cycle constants.
//   Sub-module game_timer (load/enable/zero flag, TMR_W wide).
//   Edge detection and the counters stay inline.
// TESTING (SPLASH=4, INVULN=3, BOMB=5, INIT=3/3, MAX=4)
//   Reset release -> INIT for 4 cycles, then START. enter edge -> PLAY, game_en=1, game_reset high exactly 1 cycle.
//   3 collisions, each after INVULN expires -> lives 2,1,0. Third hit -> GAMEOVER, game_en=0. Collisions inside INVULN leave num_life unchanged.
//   bomb held high for 10 cycles in PLAY -> num_bomb drops by 1 only, BOMB lasts 5 cycles, invuln=1 throughout.
//   die and collision in the same cycle -> SUCCESS, num_life unchanged. enter edge -> INIT, counters=3/3, one game_reset pulse.
//   2 life_pickups at num_life=3 -> 4 (saturates). life_pickup together with a collision -> num_life unchanged, state INVULN.
//   GAME_PAUSE_EN: pause edge at INVULN timer=1 -> PAUSE for 20 cycles, game_en=0; resume -> INVULN for 2 more cycles, then PLAY.

Source files
------------

// File: rtl/game_pkg.sv
// Shared state codes and default timing constants for the game-flow controller.
package game_pkg;

    typedef enum logic [3:0] {
        ST_INIT     = 4'b0000,
        ST_START    = 4'b0001,
        ST_PLAY     = 4'b0010,
        ST_PAUSE    = 4'b0100,
        ST_BOMB     = 4'b0110,
        ST_SUCCESS  = 4'b1000,
        ST_GAMEOVER = 4'b1001,
        ST_INVULN   = 4'b1010
    } game_state_e;

    localparam int DEF_SPLASH_CYC = 20_000_000;
    localparam int DEF_INVULN_CYC = 20_000_000;
    localparam int DEF_BOMB_CYC   = 40_000_000;

    // States in which the game logic runs and pickups are accepted.
    function automatic logic is_active(input game_state_e s);
        return (s == ST_PLAY) || (s == ST_INVULN) || (s == ST_BOMB);
    endfunction

endpackage

// File: rtl/game_timer.sv
// Down-counter for the timed states: load has priority, enable decrements, stops at zero.
module game_timer #(
    parameter int               TMR_W   = 32,
    parameter logic [TMR_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             en,
    output logic [TMR_W-1:0] cnt,
    output logic             zero
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: splash, start, play, success/gameover with life/bomb counters.
// Optional pause support is enabled by defining GAME_PAUSE_EN.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int LIFE_W     = 4,
    parameter int BOMB_W     = 4,
    parameter int LIFE_INIT  = 3,
    parameter int BOMB_INIT  = 3,
    parameter int LIFE_MAX   = 9,
    parameter int BOMB_MAX   = 9,
    parameter int TMR_W      = 32,
    parameter int SPLASH_CYC = DEF_SPLASH_CYC,
    parameter int INVULN_CYC = DEF_INVULN_CYC,
    parameter int BOMB_CYC   = DEF_BOMB_CYC
) (
    input  logic              clk,
    input  logic              hard_reset_n,
    input  logic              enter,
    input  logic              bomb,
    input  logic              collision,
    input  logic              die,
    input  logic              life_pickup,
    input  logic              bomb_pickup,
    input  logic              pause,
    output logic [LIFE_W-1:0] num_life,
    output logic [BOMB_W-1:0] num_bomb,
    output logic [3:0]        game_state,
    output logic              game_en,
    output logic              game_reset,
    output logic              invuln
);

    game_state_e       state_q, state_d;
    logic [LIFE_W-1:0] life_q, life_d;
    logic [BOMB_W-1:0] bombs_q, bombs_d;
    logic              game_en_q, game_en_d;
    logic              game_reset_q, game_reset_d;
    logic              invuln_q, invuln_d;
    logic              enter_prev_q, bomb_prev_q;

    logic              enter_edge, bomb_edge, pause_go;
    logic              tmr_load, tmr_en, tmr_zero;
    logic [TMR_W-1:0]  tmr_load_val, tmr_cnt;
    logic              life_dec, bomb_dec, pickups_ok, reload;

    assign enter_edge = enter & ~enter_prev_q;
    assign bomb_edge  = bomb & ~bomb_prev_q;

`ifdef GAME_PAUSE_EN
    game_state_e ret_q, ret_d;
    logic        pause_prev_q;
    logic        pause_edge;

    assign pause_edge = pause & ~pause_prev_q;
    assign pause_go   = pause_edge & is_active(state_q);
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign pause_go     = 1'b0;
`endif

    // The timer freezes on the cycle a pause is taken so it resumes intact.
    assign tmr_en = ((state_q == ST_INIT) || (state_q == ST_INVULN) || (state_q == ST_BOMB))
                    && !pause_go;

    game_timer #(
        .TMR_W   (TMR_W),
        .RST_VAL (TMR_W'(SPLASH_CYC - 1))
    ) u_timer (
        .clk      (clk),
        .rst_n    (hard_reset_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        game_reset_d = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        life_dec     = 1'b0;
        bomb_dec     = 1'b0;
        reload       = 1'b0;
        pickups_ok   = is_active(state_q);
`ifdef GAME_PAUSE_EN
        ret_d        = ret_q;
`endif
        if (pause_go) begin
`ifdef GAME_PAUSE_EN
            ret_d   = state_q;
            state_d = ST_PAUSE;
`endif
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (tmr_zero) state_d = ST_START;
                end
                ST_START: begin
                    if (enter_edge) begin
                        state_d      = ST_PLAY;
                        game_reset_d = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (die) begin
                        state_d = ST_SUCCESS;
                    end else if (collision) begin
                        life_dec = 1'b1;
                        // A same-cycle life pickup cancels the hit, so the player survives.
                        if ((life_q <= LIFE_W'(1)) && !life_pickup) begin
                            state_d = ST_GAMEOVER;
                        end else begin
                            state_d      = ST_INVULN;
                            tmr_load     = 1'b1;
                            tmr_load_val = TMR_W'(INVULN_CYC - 1);
                        end
                    end else if (bomb_edge && (bombs_q != '0)) begin
                        bomb_dec     = 1'b1;
                        state_d      = ST_BOMB;
                        tmr_load     = 1'b1;
                        tmr_load_val = TMR_W'(BOMB_CYC - 1);
                    end
                end
                ST_INVULN: begin
                    if (die) begin
                        state_d = ST_SUCCESS;
                    end else if (bomb_edge && (bombs_q != '0)) begin
                        bomb_dec     = 1'b1;
                        state_d      = ST_BOMB;
                        tmr_load     = 1'b1;
                        tmr_load_val = TMR_W'(BOMB_CYC - 1);
                    end else if (tmr_zero) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_BOMB: begin
                    if (die) begin
                        state_d = ST_SUCCESS;
                    end else if (tmr_zero) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_SUCCESS, ST_GAMEOVER: begin
                    if (enter_edge) begin
                        state_d      = ST_INIT;
                        reload       = 1'b1;
                        game_reset_d = 1'b1;
                        tmr_load     = 1'b1;
                        tmr_load_val = TMR_W'(SPLASH_CYC - 1);
                    end
                end
`ifdef GAME_PAUSE_EN
                ST_PAUSE: begin
                    if (pause_edge) state_d = ret_q;
                end
`endif
                default: state_d = ST_INIT;
            endcase
        end

        life_d  = life_q;
        bombs_d = bombs_q;
        if (reload) begin
            life_d  = LIFE_W'(LIFE_INIT);
            bombs_d = BOMB_W'(BOMB_INIT);
        end else begin
            if (pickups_ok && life_pickup && !life_dec) begin
                if (life_q < LIFE_W'(LIFE_MAX)) life_d = life_q + 1'b1;
            end else if (life_dec && !(pickups_ok && life_pickup) && (life_q != '0)) begin
                life_d = life_q - 1'b1;
            end
            if (pickups_ok && bomb_pickup && !bomb_dec) begin
                if (bombs_q < BOMB_W'(BOMB_MAX)) bombs_d = bombs_q + 1'b1;
            end else if (bomb_dec && !(pickups_ok && bomb_pickup) && (bombs_q != '0)) begin
                bombs_d = bombs_q - 1'b1;
            end
        end

        game_en_d = is_active(state_d);
        invuln_d  = (state_d == ST_INVULN) || (state_d == ST_BOMB);
    end

    always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            state_q      <= ST_INIT;
            life_q       <= LIFE_W'(LIFE_INIT);
            bombs_q      <= BOMB_W'(BOMB_INIT);
            game_en_q    <= 1'b0;
            game_reset_q <= 1'b0;
            invuln_q     <= 1'b0;
            enter_prev_q <= 1'b0;
            bomb_prev_q  <= 1'b0;
`ifdef GAME_PAUSE_EN
            ret_q        <= ST_PLAY;
            pause_prev_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            life_q       <= life_d;
            bombs_q      <= bombs_d;
            game_en_q    <= game_en_d;
            game_reset_q <= game_reset_d;
            invuln_q     <= invuln_d;
            enter_prev_q <= enter;
            bomb_prev_q  <= bomb;
`ifdef GAME_PAUSE_EN
            ret_q        <= ret_d;
            pause_prev_q <= pause;
`endif
        end
    end

    assign num_life   = life_q;
    assign num_bomb   = bombs_q;
    assign game_state = state_q;
    assign game_en    = game_en_q;
    assign game_reset = game_reset_q;
    assign invuln     = invuln_q;

endmodule
